// File: rtl/knn_pkg.sv
// knn_pkg
// Definitions shared by the KNN classifier's window writer and the classifier:
//   - default window and image geometry
//   - RGB565 pixel type
//   - capture FSM state encoding
//   - 11-bit widening helper used for overflow-free coordinate sums
package knn_pkg;

  localparam int WIN_DEF   = 5;
  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;

  // Coordinate ports are 10 bits; window arithmetic is done one bit wider.
  localparam int COORD_W = 10;
  localparam int SUM_W   = COORD_W + 1;

  // Row/column offsets inside the window; WIN is limited to 8.
  localparam int IDX_W = 3;

  typedef logic [15:0] rgb565_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_READY   = 2'd3
  } cap_state_e;

  function automatic logic [SUM_W-1:0] ext11(input logic [COORD_W-1:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/knn_raster_cnt.sv
// knn_raster_cnt
// Tracks the raster position of the camera pixel stream.
//   i_clk_en     system clock, rising edge
//   i_reset      asynchronous reset, active-high
//   i_pix_valid  a pixel is present this cycle
//   i_pix_sof    start of frame, qualified by i_pix_valid; that pixel is (0,0)
//   o_x, o_y     coordinate of the pixel presented this cycle
//   o_pix_ok     pixel is valid and lies inside a synchronised frame
// Pixels before the first sof, and pixels after the last line of a frame,
// are flagged as not ok until the next sof.
module knn_raster_cnt
  import knn_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic               i_clk_en,
  input  logic               i_reset,
  input  logic               i_pix_valid,
  input  logic               i_pix_sof,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_pix_ok
);

  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic               r_sync;   // at least one sof seen since reset

  logic [COORD_W-1:0] w_x;
  logic [COORD_W-1:0] w_y;
  logic               w_ok;

  // sof overrides the running counters so the sof pixel itself is (0,0).
  always_comb begin
    w_x  = i_pix_sof ? '0 : r_x;
    w_y  = i_pix_sof ? '0 : r_y;
    w_ok = i_pix_valid && (i_pix_sof || (r_sync && (r_y < COORD_W'(IMG_H))));
  end

  always_ff @(posedge i_clk_en or posedge i_reset) begin
    if (i_reset) begin
      r_x    <= '0;
      r_y    <= '0;
      r_sync <= 1'b0;
    end else if (w_ok) begin
      r_sync <= 1'b1;
      if (w_x == COORD_W'(IMG_W - 1)) begin
        r_x <= '0;
        r_y <= w_y + 1'b1;
      end else begin
        r_x <= w_x + 1'b1;
        r_y <= w_y;
      end
    end
  end

  assign o_x      = w_x;
  assign o_y      = w_y;
  assign o_pix_ok = w_ok;

endmodule

// File: rtl/knn_win_capture.sv
// knn_win_capture
// Writer side of the KNN classifier's image window. On request, captures a
// WIN x WIN patch of the next camera frame at a programmed top-left corner
// and holds it, frozen, until the classifier releases it.
//   i_clk_en            system clock, rising edge
//   i_reset             asynchronous reset, active-high
//   i_pix_valid/i_pix_sof/i_pix_data   camera RGB565 stream
//   i_win_x, i_win_y    window top-left, sampled on an accepted i_cap_req
//   i_cap_req           one-cycle capture request (honoured in IDLE only)
//   i_release           one-cycle pulse, buffer may be reused (READY only)
//   i_rd_i, i_rd_j      read row/column; out-of-window addresses return 0
//   o_rd_data           buffer[i_rd_i][i_rd_j], combinational
//   o_win_ready         buffer complete and frozen
//   o_busy              waiting for a frame or capturing
//   o_cap_err           one-cycle pulse, request rejected (window off-frame)
module knn_win_capture
  import knn_pkg::*;
#(
  parameter int WIN   = WIN_DEF,
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic               i_clk_en,
  input  logic               i_reset,
  input  logic               i_pix_valid,
  input  logic               i_pix_sof,
  input  rgb565_t            i_pix_data,
  input  logic [COORD_W-1:0] i_win_x,
  input  logic [COORD_W-1:0] i_win_y,
  input  logic               i_cap_req,
  input  logic               i_release,
  input  logic [COORD_W-1:0] i_rd_i,
  input  logic [COORD_W-1:0] i_rd_j,
  output rgb565_t            o_rd_data,
  output logic               o_win_ready,
  output logic               o_busy,
  output logic               o_cap_err
);

  if (WIN > 8 || WIN < 1) begin : g_bad_win
    $error("knn_win_capture: WIN must be in 1..8");
  end

  cap_state_e         r_state;
  cap_state_e         w_state_next;
  logic               r_cap_err;
  logic               w_cap_err_next;
  logic [COORD_W-1:0] r_lx;
  logic [COORD_W-1:0] r_ly;
  rgb565_t            r_buf [WIN][WIN];

  logic [COORD_W-1:0] w_x;
  logic [COORD_W-1:0] w_y;
  logic               w_pix_ok;

  knn_raster_cnt #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_raster (
    .i_clk_en    (i_clk_en),
    .i_reset     (i_reset),
    .i_pix_valid (i_pix_valid),
    .i_pix_sof   (i_pix_sof),
    .o_x         (w_x),
    .o_y         (w_y),
    .o_pix_ok    (w_pix_ok)
  );

  // ---------------------------------------------------------------------
  // Window geometry
  // ---------------------------------------------------------------------
  logic             w_req_bad;
  logic             w_sof_px;
  logic             w_eval;
  logic [SUM_W-1:0] w_x_end;
  logic [SUM_W-1:0] w_y_end;
  logic             w_in_win;
  logic             w_last;
  logic             w_wr;
  logic [IDX_W-1:0] w_row;
  logic [IDX_W-1:0] w_col;

  always_comb begin
    w_req_bad = (ext11(i_win_x) > SUM_W'(IMG_W - WIN)) ||
                (ext11(i_win_y) > SUM_W'(IMG_H - WIN));
    w_sof_px  = i_pix_valid && i_pix_sof;
    // In ARMED the sof pixel that starts the frame is already a candidate.
    w_eval    = w_pix_ok && ((r_state == ST_CAPTURE) ||
                             ((r_state == ST_ARMED) && w_sof_px));
    w_x_end   = ext11(r_lx) + SUM_W'(WIN);
    w_y_end   = ext11(r_ly) + SUM_W'(WIN);
    w_in_win  = (ext11(w_x) >= ext11(r_lx)) && (ext11(w_x) < w_x_end) &&
                (ext11(w_y) >= ext11(r_ly)) && (ext11(w_y) < w_y_end);
    w_last    = (ext11(w_x) == w_x_end - 1'b1) && (ext11(w_y) == w_y_end - 1'b1);
    w_wr      = w_eval && w_in_win;
    // Offsets are below WIN <= 8, so the low bits alone give the exact difference.
    w_row     = w_y[IDX_W-1:0] - r_ly[IDX_W-1:0];
    w_col     = w_x[IDX_W-1:0] - r_lx[IDX_W-1:0];
  end

  // ---------------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    w_cap_err_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_cap_req) begin
          if (w_req_bad) w_cap_err_next = 1'b1;
          else           w_state_next   = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (w_sof_px) w_state_next = (w_wr && w_last) ? ST_READY : ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (w_wr && w_last) w_state_next = ST_READY;
      end
      ST_READY: begin
        if (i_release) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_en or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_cap_err <= 1'b0;
      r_lx      <= '0;
      r_ly      <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cap_err <= w_cap_err_next;
      if ((r_state == ST_IDLE) && i_cap_req && !w_req_bad) begin
        r_lx <= i_win_x;
        r_ly <= i_win_y;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Patch buffer: one register row per window line
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < WIN; gi++) begin : g_row
    always_ff @(posedge i_clk_en or posedge i_reset) begin
      if (i_reset) begin
        for (int j = 0; j < WIN; j++) r_buf[gi][j] <= '0;
      end else if (w_wr && (w_row == IDX_W'(gi))) begin
        r_buf[gi][w_col] <= i_pix_data;
      end
    end
  end

  always_comb begin
    o_rd_data = '0;
    if ((i_rd_i < COORD_W'(WIN)) && (i_rd_j < COORD_W'(WIN)))
      o_rd_data = r_buf[i_rd_i[IDX_W-1:0]][i_rd_j[IDX_W-1:0]];
  end

  assign o_win_ready = (r_state == ST_READY);
  assign o_busy      = (r_state == ST_ARMED) || (r_state == ST_CAPTURE);
  assign o_cap_err   = r_cap_err;

endmodule

// File: tb/tb_knn_win_capture.sv
module tb_knn_win_capture;
  import knn_pkg::*;

  localparam int W  = 5;
  localparam int IW = 16;
  localparam int IH = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_valid = 1'b0;
  logic        pix_sof = 1'b0;
  logic [15:0] pix_data = '0;
  logic [9:0]  win_x = '0;
  logic [9:0]  win_y = '0;
  logic        cap_req = 1'b0;
  logic        rel = 1'b0;
  logic [9:0]  rd_i;
  logic [9:0]  rd_j;
  logic [15:0] rd_data;
  logic        win_ready;
  logic        busy;
  logic        cap_err;

  // read address is owned by the monitor except while the stimulus selects it
  logic        s_sel = 1'b0;
  logic [9:0]  s_rd_i = '0, s_rd_j = '0, m_rd_i = '0, m_rd_j = '0;
  assign rd_i = s_sel ? s_rd_i : m_rd_i;
  assign rd_j = s_sel ? s_rd_j : m_rd_j;

  knn_win_capture #(.WIN(W), .IMG_W(IW), .IMG_H(IH)) dut (
    .i_clk_en    (clk),
    .i_reset     (rst),
    .i_pix_valid (pix_valid),
    .i_pix_sof   (pix_sof),
    .i_pix_data  (pix_data),
    .i_win_x     (win_x),
    .i_win_y     (win_y),
    .i_cap_req   (cap_req),
    .i_release   (rel),
    .i_rd_i      (rd_i),
    .i_rd_j      (rd_j),
    .o_rd_data   (rd_data),
    .o_win_ready (win_ready),
    .o_busy      (busy),
    .o_cap_err   (cap_err)
  );

  always #50 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit              is_err;
    int              cyc;
    logic [24:0][15:0] data;
  } exp_t;

  exp_t sb[$];

  int tgt_x = -100, tgt_y = -100;
  int last_px_cyc = -1;

  function automatic logic [15:0] pix_val(input int f, input int x, input int y);
    return {f[3:0], y[3:0], x[7:0]};
  endfunction

  // A completed capture holds the image of frame f at the window position.
  task automatic push_win(input int f, input int wx, input int wy);
    exp_t e;
    e.is_err = 1'b0;
    e.cyc    = 0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        e.data[i*W+j] = pix_val(f, wx + j, wy + i);
    sb.push_back(e);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step_in(input bit v, input bit s, input logic [15:0] d, input bit c, input bit r);
    @(posedge clk); #1;
    pix_valid = v; pix_sof = s; pix_data = d; cap_req = c; rel = r;
  endtask

  task automatic idle(input int n);
    repeat (n) step_in(0, 0, '0, 0, 0);
  endtask

  task automatic drive_frame(input int f, input int rows, input bit gaps);
    for (int y = 0; y < rows; y++)
      for (int x = 0; x < IW; x++) begin
        if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        step_in(1, (x == 0 && y == 0), pix_val(f, x, y), 0, 0);
        if (x == tgt_x + W - 1 && y == tgt_y + W - 1) last_px_cyc = cyc;
      end
    idle(1);
  endtask

  task automatic arm(input int f, input int wx, input int wy);
    win_x = 10'(wx); win_y = 10'(wy);
    step_in(0, 0, '0, 1, 0);
    tgt_x = wx; tgt_y = wy;
    push_win(f, wx, wy);
    idle(1);
    chk("busy_armed", busy, 1);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!win_ready && n < 500) begin @(negedge clk); n++; end
    chk("ready_seen", win_ready, 1);
  endtask

  // mode 0: plain release; 1: cap_req ignored in READY first; 2: cap_req+release together
  task automatic finish_capture(input int mode);
    wait_ready();
    idle(2);
    if (mode == 1) begin
      win_x = 10'd1; win_y = 10'd1;
      step_in(0, 0, '0, 1, 0);
      idle(1);
      chk("ready_ignores_req", win_ready, 1);
      chk("busy_in_ready", busy, 0);
    end
    chk("ready_hold", win_ready, 1);
    if (mode == 2) begin
      win_x = 10'd0; win_y = 10'd0;
      step_in(0, 0, '0, 1, 1);
    end else begin
      step_in(0, 0, '0, 0, 1);
    end
    idle(1);
    chk("ready_after_rel", win_ready, 0);
    chk("busy_after_rel", busy, 0);
    if (mode == 2) begin
      drive_frame(9, 1, 0);
      chk("no_rearm_busy", busy, 0);
      chk("no_rearm_ready", win_ready, 0);
    end
  endtask

  task automatic capture(input int f, input int wx, input int wy, input bit gaps, input int mode);
    arm(f, wx, wy);
    drive_frame(f, IH, gaps);
    finish_capture(mode);
  endtask

  task automatic reject(input int wx, input int wy);
    exp_t e;
    win_x = 10'(wx); win_y = 10'(wy);
    step_in(0, 0, '0, 1, 0);
    e.is_err = 1'b1;
    e.cyc    = cyc + 1;
    e.data   = '0;
    sb.push_back(e);
    idle(2);
    chk("busy_reject", busy, 0);
    chk("ready_reject", win_ready, 0);
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    bit   prev_rdy = 1'b0;
    bit   prev_err = 1'b0;
    bit   rdy_now, err_now;
    exp_t e;
    forever begin
      @(negedge clk);
      rdy_now = win_ready;
      err_now = cap_err;
      if (err_now) begin
        chk("cap_err_width", prev_err, 0);
        chk("err_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("err_kind", e.is_err, 1);
          chk("err_cycle", cyc, e.cyc);
          chk("busy_at_err", busy, 0);
        end
      end
      if (rdy_now && !prev_rdy) begin
        chk("win_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("win_kind", e.is_err, 0);
          chk("ready_cycle", cyc, last_px_cyc + 1);
          for (int i = 0; i < W; i++)
            for (int j = 0; j < W; j++) begin
              m_rd_i = 10'(i); m_rd_j = 10'(j);
              #1;
              chk($sformatf("rd[%0d][%0d]", i, j), rd_data, e.data[i*W+j]);
            end
          m_rd_i = 10'd5; m_rd_j = 10'd0; #1;
          chk("rd_oob_row", rd_data, 0);
          m_rd_i = 10'd0; m_rd_j = 10'd5; #1;
          chk("rd_oob_col", rd_data, 0);
          m_rd_i = 10'd0; m_rd_j = 10'd0;
        end
      end
      prev_rdy = rdy_now;
      prev_err = err_now;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #(100 * 60000);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(1);
    chk("rst_ready", win_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", cap_err, 0);

    // release in IDLE is ignored
    step_in(0, 0, '0, 0, 1);
    idle(1);
    chk("idle_rel_busy", busy, 0);
    chk("idle_rel_ready", win_ready, 0);

    // basic capture, ignored cap_req in READY
    capture(1, 3, 2, 0, 1);
    // corner windows
    capture(1, 0, 0, 0, 0);
    capture(1, 11, 7, 0, 0);
    // rejections
    reject(12, 0);
    reject(0, 8);

    // cap_req while ARMED is ignored (coords and error), then combined cap_req+release
    arm(5, 4, 3);
    win_x = 10'd12; win_y = 10'd0;
    step_in(0, 0, '0, 1, 0);
    idle(1);
    chk("armed_ignores_req", busy, 1);
    drive_frame(5, IH, 1);
    finish_capture(2);

    // truncated frame: sof after row 3 of frame 1, frame 2 follows
    arm(2, 3, 2);
    drive_frame(1, 4, 0);
    drive_frame(2, IH, 0);
    finish_capture(0);

    // randomized captures and rejections
    for (int k = 0; k < 6; k++) begin
      capture($urandom_range(1, 15), $urandom_range(0, IW - W), $urandom_range(0, IH - W), 1, 0);
      if ($urandom_range(0, 1) == 1) reject($urandom_range(IW - W + 1, 1023), $urandom_range(0, IH - W));
      else                           reject($urandom_range(0, IW - W), $urandom_range(IH - W + 1, 1023));
    end

    // asynchronous reset mid-capture
    arm(7, 3, 2);
    drive_frame(7, 5, 0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_ready", win_ready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_err", cap_err, 0);
    s_sel = 1'b1;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++) begin
        s_rd_i = 10'(i); s_rd_j = 10'(j);
        #1;
        chk($sformatf("arst_rd[%0d][%0d]", i, j), rd_data, 0);
      end
    s_sel = 1'b0;
    sb.delete();
    tgt_x = -100; tgt_y = -100;
    repeat (2) @(posedge clk);
    #20 rst = 1'b0;
    capture(4, 1, 1, 1, 0);

    idle(3);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/knn_win_capture.md
Name: knn_win_capture

Overview:
- Writer side of the KNN classifier's image window.
- Watches the camera RGB565 pixel stream and tracks raster position.
- On request, captures a WIN x WIN pixel patch at a programmed top-left coordinate into a register buffer.
- Exposes the patch through a combinational row/column read port, which the classifier indexes with its i/j counters, and holds it stable until the classifier releases it.

Parameters:
- WIN, 5, window side in pixels; buffer holds WIN*WIN 16-bit words.
- IMG_W, 640, active pixels per line.
- IMG_H, 480, active lines per frame.

Ports:
- clk_en  in  1  system clock, rising edge.
- reset  in  1  asynchronous reset, active-high.
- pix_valid  in  1  pix_data carries a valid pixel this cycle.
- pix_sof  in  1  start of frame; qualified by pix_valid; marks pixel (0,0).
- pix_data  in  16  RGB565 pixel.
- win_x  in  10  window top-left column; sampled on accepted cap_req.
- win_y  in  10  window top-left row; sampled on accepted cap_req.
- cap_req  in  1  one-cycle capture request.
- release  in  1  one-cycle pulse: classifier finished, buffer may be reused.
- rd_i  in  10  read row, 0..WIN-1.
- rd_j  in  10  read column, 0..WIN-1.
- rd_data  out  16  buffer[rd_i][rd_j]; combinational.
- win_ready  out  1  level: buffer complete and frozen.
- busy  out  1  level: state is ARMED or CAPTURE.
- cap_err  out  1  one-cycle pulse: request rejected, window out of frame.

Behaviour:
- Reset (async, active-high): state IDLE; x/y counters 0; all buffer words 16'h0000; win_ready=0, busy=0, cap_err=0; latched coordinates 0.
- Raster counters (free-running, independent of state):
  - Pixel with pix_valid and pix_sof is at (0,0); next x=1, y=0.
  - Otherwise each valid pixel is at (x,y); then x increments.
  - At x=IMG_W-1, x wraps to 0 and y increments.
  - Once y reaches IMG_H, pixels are ignored (not stored) until the next sof.
  - Pixels arriving before the first sof after reset are ignored.
- FSM, states IDLE, ARMED, CAPTURE, READY:
  - IDLE, cap_req:
    - If win_x > IMG_W-WIN or win_y > IMG_H-WIN: cap_err=1 for the following cycle, stay IDLE.
    - Else latch coordinates and go to ARMED.
  - ARMED: waits for a valid pixel with pix_sof, then goes to CAPTURE. That sof pixel is itself evaluated for capture, so a window at (0,0) stores it.
  - CAPTURE: each valid pixel with latched_x <= x < latched_x+WIN and latched_y <= y < latched_y+WIN is written to buffer[y-latched_y][x-latched_x]. The write at (latched_x+WIN-1, latched_y+WIN-1) moves the FSM to READY.
  - READY: win_ready=1; buffer write-disabled; release returns to IDLE (win_ready low on the next cycle).
- Timing:
  - win_ready rises on the clock after the last window pixel is accepted.
  - Total latency from the first window pixel is one clock after the final window pixel.
- Ignored inputs:
  - cap_req outside IDLE is ignored, no error.
  - release outside READY is ignored.
  - cap_req and release in the same cycle in READY: release wins, cap_req is dropped.
- sof during CAPTURE (truncated frame): counters restart at (0,0) and capture continues into the new frame. Previously written words are overwritten as reached; no error.
- The buffer is not cleared between captures; only reset clears it.
- rd_i >= WIN or rd_j >= WIN returns 16'h0000. Reads are legal in any state; contents are guaranteed consistent only while win_ready=1.
- Arithmetic:
  - Window comparisons use 11-bit sums so that latched+WIN cannot overflow.
  - Buffer index differences are 3 bits wide for WIN <= 8. WIN > 8 is unsupported and gives an elaboration error.

Decomposition:
- Shared package knn_pkg:
  - FSM state enum.
  - RGB565 pixel typedef (16 bits).
  - Default WIN/IMG_W/IMG_H constants, also used by the classifier's window size.
- One natural sub-module, knn_raster_cnt: x/y counters with sof restart, wrap and end-of-frame ignore.
- FSM, window compare, buffer and read mux stay in knn_win_capture.

Test Plan:
Run with IMG_W=16, IMG_H=12, WIN=5; each frame drives pix_data = {f[3:0], y[3:0], x[7:0]}.
1. Basic capture:
   - Stimulus: cap_req with win_x=3, win_y=2; frame f=1.
   - Response: win_ready rises the clock after pixel (7,6).
   - Reads: rd_data[0][0]=16'h1203, [4][4]=16'h1607, [2][1]=16'h1404.
   - win_ready stays high until release, then IDLE.
2. Corner windows:
   - Stimulus: (0,0) in one run, (11,7) in another.
   - Response (0,0): the sof pixel is stored, [0][0]=16'h1000.
   - Response (11,7): [4][4]=16'h1B0F; win_ready rises after the last pixel of the frame.
3. Rejection:
   - Stimulus: win_x=12, win_y=0.
   - Response: cap_err pulses exactly one cycle, busy stays 0, FSM stays IDLE.
   - Stimulus: win_y=8.
   - Response: same as win_x=12.
4. Ignored controls:
   - Stimulus: cap_req while busy; release in IDLE.
   - Response: no state change.
   - Stimulus: cap_req+release together in READY.
   - Response: IDLE next cycle, no re-arm.
5. Truncated frame:
   - Stimulus: sof mid-capture after row 3 of frame f=1; full frame f=2 follows.
   - Response: all 25 words hold f=2 data, win_ready after (7,6) of frame f=2.
6. Reset mid-CAPTURE:
   - Stimulus: assert reset asynchronously mid-capture.
   - Response: outputs 0 immediately, all reads 16'h0000.
   - Then: a new cap_req after deassertion captures normally.
   - Out-of-range read: rd_i=5 returns 0.
